// File: rtl/gate_check_pkg.sv
// gate_check_pkg: shared states, obs bit indices and sizes for gate checkers
package gate_check_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
  localparam int IDX_AND   = 0;
  localparam int IDX_OR    = 1;
  localparam int IDX_NAND  = 2;
  localparam int IDX_NOR   = 3;
  localparam int IDX_XOR   = 4;
  localparam int IDX_XNOR  = 5;
  localparam int NUM_VEC   = 4;
  localparam int NUM_GATES = 6;
endpackage

// File: rtl/gate_golden_model.sv
// gate_golden_model: expected outputs of the six basic 2-input gates
module gate_golden_model
  import gate_check_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] expected
);
  // one bit per gate at its obs index
  always_comb begin
    expected           = '0;
    expected[IDX_AND]  = a & b;
    expected[IDX_OR]   = a | b;
    expected[IDX_NAND] = ~(a & b);
    expected[IDX_NOR]  = ~(a | b);
    expected[IDX_XOR]  = a ^ b;
    expected[IDX_XNOR] = ~(a ^ b);
  end
endmodule

// File: rtl/gate_truth_table_checker.sv
// gate_truth_table_checker: sweeps a/b through 00..11 and checks six gate outputs
module gate_truth_table_checker
  import gate_check_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 a,
  output logic                 b,
  input  logic [NUM_GATES-1:0] obs,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_GATES-1:0] fail_mask,
  output logic [2:0]           err_count
);
  state_t               state, state_n;
  logic [1:0]           vec, vec_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic                 a_n, b_n, busy_n, done_n, pass_n;
  logic [NUM_GATES-1:0] fail_mask_n, expected, mism;
  logic [2:0]           err_count_n;

  gate_golden_model u_golden (.a(a), .b(b), .expected(expected));

  // case-inequality so X/Z on obs shows up as a mismatch in simulation
  always_comb begin
    mism = '0;
    for (int i = 0; i < NUM_GATES; i++) mism[i] = obs[i] !== expected[i];
  end

  // next-state and next register values
  always_comb begin
    state_n     = state;
    vec_n       = vec;
    cnt_n       = cnt;
    a_n         = a;
    b_n         = b;
    busy_n      = busy;
    done_n      = 1'b0;
    pass_n      = pass;
    fail_mask_n = fail_mask;
    err_count_n = err_count;
    case (state)
      IDLE: if (start) begin
        state_n     = SETTLE;
        vec_n       = 2'd0;
        cnt_n       = CNT_W'(SETTLE_CYCLES);
        a_n         = 1'b0;
        b_n         = 1'b0;
        busy_n      = 1'b1;
        pass_n      = 1'b0;
        fail_mask_n = '0;
        err_count_n = 3'd0;
      end
      SETTLE: begin
        cnt_n   = cnt - CNT_W'(1);
        state_n = (cnt == CNT_W'(1)) ? CHECK : SETTLE;
      end
      CHECK: begin
        fail_mask_n = fail_mask | mism;
        err_count_n = err_count + 3'(|mism);
        if (vec == 2'(NUM_VEC - 1)) begin
          state_n = DONE;
          done_n  = 1'b1;
          pass_n  = (err_count_n == 3'd0);
        end else begin
          state_n    = SETTLE;
          vec_n      = vec + 2'd1;
          {a_n, b_n} = vec + 2'd1;
          cnt_n      = CNT_W'(SETTLE_CYCLES);
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  // state and output registers, async reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= 2'd0;
      cnt       <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= '0;
      err_count <= 3'd0;
    end else begin
      state     <= state_n;
      vec       <= vec_n;
      cnt       <= cnt_n;
      a         <= a_n;
      b         <= b_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      fail_mask <= fail_mask_n;
      err_count <= err_count_n;
    end
endmodule

// File: tb/tb_gate_truth_table_checker.sv
// tb_gate_truth_table_checker: random and directed sweeps against a truth-table model
module tb_gate_truth_table_checker;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start2 = 1'b0, start1 = 1'b0;
  logic a2, b2, busy2, done2, pass2, a1, b1, busy1, done1, pass1;
  logic [5:0] obs2, obs1, fail_mask2, fail_mask1;
  logic [2:0] err_count2, err_count1;
  logic [5:0] inj2 [4];
  logic [5:0] inj1 [4];
  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  gate_truth_table_checker #(.SETTLE_CYCLES(2), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .obs(obs2),
    .busy(busy2), .done(done2), .pass(pass2), .fail_mask(fail_mask2), .err_count(err_count2));

  gate_truth_table_checker #(.SETTLE_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .obs(obs1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_mask(fail_mask1), .err_count(err_count1));

  assign obs2 = {~(a2 ^ b2), a2 ^ b2, ~(a2 | b2), ~(a2 & b2), a2 | b2, a2 & b2} ^ inj2[{a2, b2}];
  assign obs1 = {~(a1 ^ b1), a1 ^ b1, ~(a1 | b1), ~(a1 & b1), a1 | b1, a1 & b1} ^ inj1[{a1, b1}];

  function automatic logic [5:0] ref_gates(input int x, input int y);
    int an, o, xo;
    an = x * y;
    o  = x + y - x * y;
    xo = (x + y) % 2;
    return {1'(1 - xo), 1'(xo), 1'(1 - o), 1'(1 - an), 1'(o), 1'(an)};
  endfunction

  function automatic void ref_sweep(input logic [5:0] f [4], output logic [5:0] fm, output int ec);
    logic [5:0] g, o, d;
    fm = '0;
    ec = 0;
    for (int v = 0; v < 4; v++) begin
      g = ref_gates(v / 2, v % 2);
      o = g ^ f[v];
      d = o ^ g;
      if (d != 0) ec++;
      fm |= d;
    end
  endfunction

  task automatic sweep2(input int r1, input int r2, output int dk, output int dn, output int seq_err,
                        output logic [5:0] fm, output logic [2:0] ec, output logic p);
    dk = -1; dn = 0; seq_err = 0; fm = 'x; ec = 'x; p = 1'bx;
    @(negedge clk) start2 = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done2) begin dn++; dk = k; fm = fail_mask2; ec = err_count2; p = pass2; end
      if ({a2, b2} != 2'(k < 9 ? k / 3 : 3)) seq_err++;
      if (busy2 != (k <= 12)) seq_err++;
      start2 = (k + 1 == r1) || (k + 1 == r2);
    end
  endtask

  task automatic test_reset;
    n_vec++;
    if ({a2, b2, busy2, done2, pass2} !== 5'b0) begin
      n_bad++; $display("FAIL reset_ctrl2: got %b want 00000", {a2, b2, busy2, done2, pass2});
    end
    n_vec++;
    if ({fail_mask2, err_count2} !== 9'b0) begin
      n_bad++; $display("FAIL reset_acc2: got %h want 000", {fail_mask2, err_count2});
    end
    n_vec++;
    if ({a1, b1, busy1, done1, pass1, fail_mask1, err_count1} !== 14'b0) begin
      n_bad++; $display("FAIL reset_dut1: got %h want 0", {a1, b1, busy1, done1, pass1, fail_mask1, err_count1});
    end
  endtask

  task automatic run_case(input string nm, input int r1, input int r2);
    int dk, dn, se, eec;
    logic [5:0] fm, efm;
    logic [2:0] ec;
    logic p;
    ref_sweep(inj2, efm, eec);
    sweep2(r1, r2, dk, dn, se, fm, ec, p);
    n_vec++;
    if (dk != 12 || dn != 1) begin
      n_bad++; $display("FAIL %s_done: got edge %0d pulses %0d want edge 12 pulses 1", nm, dk, dn);
    end
    n_vec++;
    if (se != 0) begin n_bad++; $display("FAIL %s_seq: got %0d errors want 0", nm, se); end
    n_vec++;
    if (fm !== efm) begin n_bad++; $display("FAIL %s_mask: got %b want %b", nm, fm, efm); end
    n_vec++;
    if (ec !== 3'(eec)) begin n_bad++; $display("FAIL %s_errs: got %0d want %0d", nm, ec, eec); end
    n_vec++;
    if (p !== (eec == 0) || pass2 !== (eec == 0)) begin
      n_bad++; $display("FAIL %s_pass: got %b/%b want %b", nm, p, pass2, eec == 0);
    end
  endtask

  task automatic test_clean;
    for (int v = 0; v < 4; v++) inj2[v] = '0;
    run_case("clean", 0, 0);
  endtask

  task automatic test_stuck_and;
    for (int v = 0; v < 4; v++) inj2[v] = '0;
    inj2[3] = 6'b000001;
    run_case("stuck_and", 0, 0);
  endtask

  task automatic test_xor_swap;
    for (int v = 0; v < 4; v++) inj2[v] = 6'b110000;
    run_case("xor_swap", 0, 0);
  endtask

  task automatic test_restart_ignored;
    for (int v = 0; v < 4; v++) inj2[v] = '0;
    run_case("restart", 3, 7);
  endtask

  task automatic test_random;
    for (int t = 0; t < 6; t++) begin
      for (int v = 0; v < 4; v++) inj2[v] = ($urandom_range(0, 1) != 0) ? 6'($urandom) : 6'b0;
      run_case("random", 0, 0);
    end
  endtask

  task automatic test_reset_mid;
    int dseen = 0;
    for (int v = 0; v < 4; v++) inj2[v] = 6'b000010;
    @(negedge clk) start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({a2, b2, busy2, done2} !== 4'b0 || fail_mask2 !== 6'b0) begin
      n_bad++; $display("FAIL reset_mid: got ab=%b%b busy=%b done=%b mask=%b want all 0", a2, b2, busy2, done2, fail_mask2);
    end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (15) begin @(posedge clk); #1 if (done2 || busy2) dseen++; end
    n_vec++;
    if (dseen != 0) begin n_bad++; $display("FAIL reset_mid_nodone: got %0d active cycles want 0", dseen); end
    for (int v = 0; v < 4; v++) inj2[v] = '0;
    run_case("after_reset", 0, 0);
  endtask

  task automatic test_back_to_back;
    int d1 = -1, d2 = -1, eec;
    logic [5:0] efm, fm_a, fm_b;
    logic [2:0] ec_a, ec_b;
    logic p_a, p_b;
    for (int v = 0; v < 4; v++) inj1[v] = '0;
    inj1[0] = 6'b000100;
    ref_sweep(inj1, efm, eec);
    @(negedge clk) start1 = 1'b1;
    for (int k = 0; k <= 22; k++) begin
      @(posedge clk); #1;
      if (done1) begin
        if (d1 < 0) begin
          d1 = k; fm_a = fail_mask1; ec_a = err_count1; p_a = pass1;
          for (int v = 0; v < 4; v++) inj1[v] = '0;
        end else begin
          d2 = k; fm_b = fail_mask1; ec_b = err_count1; p_b = pass1;
        end
      end
      if (k == 10) begin
        n_vec++;
        if (!busy1 || fail_mask1 !== 6'b0 || err_count1 !== 3'd0) begin
          n_bad++; $display("FAIL b2b_clear: got busy=%b mask=%b errs=%0d want 1/0/0", busy1, fail_mask1, err_count1);
        end
      end
      if (k == 18) start1 = 1'b0;
    end
    n_vec++;
    if (d1 != 8 || d2 != 18) begin n_bad++; $display("FAIL b2b_done: got %0d,%0d want 8,18", d1, d2); end
    n_vec++;
    if (fm_a !== efm || ec_a !== 3'(eec) || p_a !== 1'b0) begin
      n_bad++; $display("FAIL b2b_first: got %b/%0d/%b want %b/%0d/0", fm_a, ec_a, p_a, efm, eec);
    end
    n_vec++;
    if (fm_b !== 6'b0 || ec_b !== 3'd0 || p_b !== 1'b1) begin
      n_bad++; $display("FAIL b2b_second: got %b/%0d/%b want 000000/0/1", fm_b, ec_b, p_b);
    end
  endtask

  initial begin
    for (int v = 0; v < 4; v++) begin inj2[v] = '0; inj1[v] = '0; end
    repeat (2) @(posedge clk);
    #1 test_reset;
    @(negedge clk) rst_n = 1'b1;
    test_clean;
    test_stuck_and;
    test_xor_swap;
    test_restart_ignored;
    test_random;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/gate_truth_table_checker.md
Name: gate_truth_table_checker

Overview:
Hardware stimulus-and-response checker for the 2-input basic-gate block (AND, OR, NAND, NOR, XOR, XNOR). When `start` is seen, it drives the a/b inputs of the device under check (DUT) through all four combinations 00, 01, 10, 11. After each combination it waits a programmable settle time, then compares the six DUT outputs against a golden model. It sits beside the gate block as an on-chip self-test and reports a pass/fail summary.

Parameters:
SETTLE_CYCLES, 2, cycles from applying a vector to sampling the DUT outputs; legal range 1..255.
CNT_W, 8, width of the settle counter; must hold SETTLE_CYCLES.

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
start  input  1  begin a sweep; sampled only in IDLE.
a  output  1  DUT input a, registered.
b  output  1  DUT input b, registered.
obs  input  6  DUT outputs: [0]=and [1]=or [2]=nand [3]=nor [4]=xor [5]=xnor.
busy  output  1  high from the start-accept edge until DONE is exited.
done  output  1  one-cycle pulse when the sweep completes.
pass  output  1  high when the last completed sweep had zero mismatches; held until next start.
fail_mask  output  6  sticky OR of the per-bit mismatches over the sweep.
err_count  output  3  number of vectors with any mismatch (0..4).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; a=b=0; busy=done=pass=0; fail_mask=0; err_count=0; vec=0; cnt=0.
- States and transitions:
  - IDLE: on start=1 → SETTLE. On that edge: a,b<=00, vec<=0, cnt<=SETTLE_CYCLES, fail_mask<=0, err_count<=0, pass<=0, busy<=1.
  - SETTLE: cnt decrements each cycle; when cnt==1 → CHECK. The state lasts exactly SETTLE_CYCLES cycles.
  - CHECK (1 cycle):
    - mism = obs XOR expected({a,b}).
    - fail_mask |= mism.
    - err_count += (mism!=0).
    - If vec==3 → DONE. Else vec++, {a,b}<=vec+1, cnt<=SETTLE_CYCLES → SETTLE.
  - DONE (1 cycle): done=1. pass = (final err_count==0), computed from the updated count so the last vector is included. busy drops with the transition to IDLE; a,b hold 11.
- Latency: done is high in the cycle after edge 4*(SETTLE_CYCLES+1) counted from the start-sampling edge. With SETTLE_CYCLES=2 that is edge 12.
- Golden model: and=a&b, or=a|b, nand=~(a&b), nor=~(a|b), xor=a^b, xnor=~(a^b).
- Boundary conditions:
  - start while busy: ignored, with no effect on the sweep.
  - start held high continuously: a new sweep begins on the first IDLE cycle after DONE.
  - Reset mid-sweep: immediate return to reset values; no done pulse.
  - Unknown values (X/Z) on obs in simulation count as a mismatch (case-inequality compare).
  - err_count saturates naturally at 4; no wrap is possible.
- All outputs are registered; there are no combinational paths from obs to any output.

Decomposition:
- Shared package gate_check_pkg holds:
  - state encodings IDLE/SETTLE/CHECK/DONE (2 bits);
  - obs bit-index constants IDX_AND..IDX_XNOR;
  - NUM_VEC=4 and NUM_GATES=6.
- Sub-module gate_golden_model: purely combinational, maps (a,b) to the 6-bit expected vector. It is reused by other checkers.
- The FSM, counters and accumulators stay in the top module.

Test Plan:
1. Correct gate block connected, SETTLE_CYCLES=2, pulse start → vectors 00,01,10,11 each held 3 cycles; done at edge 12; pass=1, err_count=0, fail_mask=6'b000000.
2. obs[0] stuck at 0 → mismatch only on vector 11; err_count=1, fail_mask=6'b000001, pass=0.
3. DUT with xor/xnor swapped → all four vectors mismatch; err_count=4, fail_mask=6'b110000, pass=0.
4. start re-pulsed at edges 3 and 7 of a sweep → ignored; done still at edge 12, results identical to scenario 1.
5. rst_n low at edge 5 mid-sweep → a=b=0, busy=0, no done pulse; a new start gives a full normal sweep.
6. SETTLE_CYCLES=1, back-to-back sweeps (fault in sweep 1, clean in sweep 2) → done at edge 8 for each; fail_mask and err_count cleared at the second start; second sweep pass=1.
